// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Definitions shared by the sequential ALU and its iterative datapath.
//   - Opcode encodings for op[4:0] (OP_ADD .. OP_SHL). Any other value is
//     reported as unknown.
//   - Bit positions inside the 8-bit o_flags vector.
//   - State encoding of the top-level control FSM.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_CMP  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_NAND = 5'd9;
    localparam logic [4:0] OP_NOR  = 5'd10;
    localparam logic [4:0] OP_XNOR = 5'd11;
    localparam logic [4:0] OP_ZZ   = 5'd12;
    localparam logic [4:0] OP_SHR  = 5'd13;
    localparam logic [4:0] OP_SHL  = 5'd14;

    // o_flags = {2'b0, UNKNWN, DIV0, EQ, GT, UNDERFLOW, OVERFLOW}
    localparam int FLG_OVF  = 0;
    localparam int FLG_UNF  = 1;
    localparam int FLG_GT   = 2;
    localparam int FLG_EQ   = 3;
    localparam int FLG_DIV0 = 4;
    localparam int FLG_UNK  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// -----------------------------------------------------------------------------
// seq_alu_iter
//   Iterative multiply / divide datapath, one bit per clock.
//   MUL: right-shifting shift-add. {hi, lo} starts as {0, b}; each step adds
//        a into hi when lo[0] is set and shifts the pair right by one.
//   DIV: restoring shift-subtract. hi is the partial remainder, lo starts as
//        the dividend and collects quotient bits from the right.
//   The run lasts BITS cycles after the start edge. done is asserted during
//   the last step, and res_hi/res_lo present the values being written on
//   that edge, so the caller can capture the final result on the same edge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin a run (ignored mid-run by design
//                of the caller, which only starts from idle)
//   is_div       1 = divide, 0 = multiply (sampled with start)
//   op_a, op_b   operands (sampled with start); DIV computes op_a / op_b
//   done         last step in progress this cycle
//   res_hi       MUL: high product half; DIV: remainder
//   res_lo       MUL: low product half;  DIV: quotient
// -----------------------------------------------------------------------------
module seq_alu_iter #(
    parameter int BITS      = 8,
    parameter int LOG2_BITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [BITS-1:0] op_a,
    input  logic [BITS-1:0] op_b,
    output logic            done,
    output logic [BITS-1:0] res_hi,
    output logic [BITS-1:0] res_lo
);

    localparam int CNT_W = LOG2_BITS + 1;

    logic [BITS-1:0]  hi_q, hi_d;
    logic [BITS-1:0]  lo_q, lo_d;
    logic [BITS-1:0]  opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;

    logic [BITS:0]    mul_sum;
    logic [BITS:0]    trial;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        div_d  = div_q;

        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        // Shift the next dividend bit into the remainder and try the
        // subtraction; bit BITS of the difference is the borrow.
        trial   = {hi_q, lo_q[BITS-1]} - {1'b0, opnd_q};

        if (start) begin
            hi_d   = '0;
            lo_d   = is_div ? op_a : op_b;
            opnd_d = is_div ? op_b : op_a;
            cnt_d  = CNT_W'(BITS);
            div_d  = is_div;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                if (!trial[BITS]) begin
                    hi_d = trial[BITS-1:0];
                    lo_d = {lo_q[BITS-2:0], 1'b1};
                end else begin
                    // Remainder is below the divisor, so its MSB is zero
                    // and dropping it loses nothing.
                    hi_d = {hi_q[BITS-2:0], lo_q[BITS-1]};
                    lo_d = {lo_q[BITS-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sum[BITS:1];
                lo_d = {mul_sum[0], lo_q[BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
        end
    end

    assign done   = (cnt_q == CNT_W'(1));
    assign res_hi = hi_d;
    assign res_lo = lo_d;

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Multi-cycle handshaked ALU. MUL and DIV (b != 0) run BITS cycles in
//   seq_alu_iter; every other op is computed combinationally from the inputs
//   and registered on the accept edge. Results are held until consumed.
//   Handshake: an op is accepted on a rising edge with in_valid && in_ready;
//   a result is consumed on a rising edge with out_valid && out_ready.
//   in_ready is high in IDLE, and in DONE while out_ready is high, so a new
//   op can replace a consumed result on the same edge.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for a, b, op
//   a, b                operands (b is also the shift amount)
//   op                  [4:0] opcode, [7:5] modifier flags
//   out_valid/out_ready output handshake for z, o_flags
//   z                   result
//   o_flags             {2'b0, UNKNWN, DIV0, EQ, GT, UNDERFLOW, OVERFLOW}
// Configuration:
//   SEQ_ALU_MULHI_EN    when defined, MUL with op[5]=1 returns the high half
//                       of the product (OVERFLOW then reads 0).
// -----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int LOG2_BITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [7:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] z,
    output logic [7:0]      o_flags
);

    if (LOG2_BITS != $clog2(BITS) || BITS < 4) begin : g_bad_param
        $error("seq_alu: BITS must be >= 4 and LOG2_BITS must equal $clog2(BITS)");
    end

    localparam logic [BITS-1:0] BITS_V = BITS'(BITS);

    state_e          state_q, state_d;
    logic [BITS-1:0] z_q, z_d;
    logic [7:0]      flags_q, flags_d;
    logic            div_q, div_d;
`ifdef SEQ_ALU_MULHI_EN
    logic            mulhi_q, mulhi_d;
`endif

    logic            accept;
    logic            iter_op;
    logic            iter_start;
    logic            iter_done;
    logic [BITS-1:0] iter_hi;
    logic [BITS-1:0] iter_lo;

    // Single-cycle datapath
    logic [BITS-1:0]   alu_z;
    logic [7:0]        alu_flags;
    logic [BITS:0]     add_w;
    logic [BITS-1:0]   rot_amt;
    logic [2*BITS-1:0] shl_w, shr_w, rotl_w, rotr_w;
    logic [2:0]        mods;
    logic              a_gt_b, a_lt_b, a_eq_b;

    always_comb begin
        alu_z     = '0;
        alu_flags = '0;
        mods      = op[7:5];
        a_gt_b    = (a > b);
        a_lt_b    = (a < b);
        a_eq_b    = (a == b);
        add_w     = {1'b0, a} + {1'b0, b};
        rot_amt   = b % BITS_V;
        // Shifting inside a double-width word leaves the bits pushed out in
        // the other half, which gives the lost-bit flag directly.
        shl_w     = {{BITS{1'b0}}, a} << b;
        shr_w     = {a, {BITS{1'b0}}} >> b;
        rotl_w    = {a, a} << rot_amt;
        rotr_w    = {a, a} >> rot_amt;

        case (op[4:0])
            OP_ADD: begin
                alu_z              = add_w[BITS-1:0];
                alu_flags[FLG_OVF] = add_w[BITS];
            end
            OP_SUB: begin
                alu_z              = a - b;
                alu_flags[FLG_UNF] = a_lt_b;
            end
            OP_MUL: begin
                // Always iterative; never reaches this result path.
                alu_z = '0;
            end
            OP_DIV: begin
                // Only b == 0 completes here.
                alu_z               = '0;
                alu_flags[FLG_DIV0] = 1'b1;
            end
            OP_CMP: begin
                // "greater or less" and "always" select nothing.
                if (mods != 3'b011 && mods != 3'b111) begin
                    alu_z[0] = (mods[0] && a_gt_b) || (mods[1] && a_lt_b) ||
                               (mods[2] && a_eq_b);
                end
                alu_flags[FLG_GT] = a_gt_b;
                alu_flags[FLG_EQ] = a_eq_b;
            end
            OP_AND:  alu_z = a & b;
            OP_OR:   alu_z = a | b;
            OP_XOR:  alu_z = a ^ b;
            OP_NOT:  alu_z = ~a;
            OP_NAND: alu_z = ~(a & b);
            OP_NOR:  alu_z = ~(a | b);
            OP_XNOR: alu_z = ~(a ^ b);
            OP_ZZ: begin
                if (op[7]) begin
                    alu_z = {a[0], a[BITS-1:1] ^ {(BITS-1){a[0]}}};
                end else begin
                    alu_z = {a[BITS-2:0] ^ {(BITS-1){a[BITS-1]}}, a[BITS-1]};
                end
            end
            OP_SHR: begin
                if (op[5]) begin
                    alu_z = rotr_w[BITS-1:0];
                end else if (b >= BITS_V) begin
                    alu_z              = '0;
                    alu_flags[FLG_UNF] = |a;
                end else begin
                    alu_z              = shr_w[2*BITS-1:BITS];
                    alu_flags[FLG_UNF] = |shr_w[BITS-1:0];
                end
            end
            OP_SHL: begin
                if (op[5]) begin
                    alu_z = rotl_w[2*BITS-1:BITS];
                end else if (b >= BITS_V) begin
                    alu_z              = '0;
                    alu_flags[FLG_OVF] = |a;
                end else begin
                    alu_z              = shl_w[BITS-1:0];
                    alu_flags[FLG_OVF] = |shl_w[2*BITS-1:BITS];
                end
            end
            default: begin
                alu_z              = '0;
                alu_flags[FLG_UNK] = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign iter_op   = (op[4:0] == OP_MUL) || ((op[4:0] == OP_DIV) && (b != '0));
    assign out_valid = (state_q == ST_DONE);
    assign z         = z_q;
    assign o_flags   = flags_q;

    // Control FSM
    always_comb begin
        state_d    = state_q;
        z_d        = z_q;
        flags_d    = flags_q;
        div_d      = div_q;
        iter_start = 1'b0;
`ifdef SEQ_ALU_MULHI_EN
        mulhi_d    = mulhi_q;
`endif

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_d = ST_DONE;
                    flags_d = '0;
                    if (div_q) begin
                        z_d = iter_lo;
                    end else begin
`ifdef SEQ_ALU_MULHI_EN
                        z_d              = mulhi_q ? iter_hi : iter_lo;
                        flags_d[FLG_OVF] = !mulhi_q && (iter_hi != '0);
`else
                        z_d              = iter_lo;
                        flags_d[FLG_OVF] = (iter_hi != '0);
`endif
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new op may be taken from IDLE, or from DONE on the edge the
        // previous result is consumed.
        if (accept) begin
            if (iter_op) begin
                state_d    = ST_BUSY;
                iter_start = 1'b1;
                div_d      = (op[4:0] == OP_DIV);
`ifdef SEQ_ALU_MULHI_EN
                mulhi_d    = op[5];
`endif
            end else begin
                state_d = ST_DONE;
                z_d     = alu_z;
                flags_d = alu_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
            flags_q <= '0;
            div_q   <= 1'b0;
`ifdef SEQ_ALU_MULHI_EN
            mulhi_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            flags_q <= flags_d;
            div_q   <= div_d;
`ifdef SEQ_ALU_MULHI_EN
            mulhi_q <= mulhi_d;
`endif
        end
    end

    seq_alu_iter #(
        .BITS      (BITS),
        .LOG2_BITS (LOG2_BITS)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_div (op[4:0] == OP_DIV),
        .op_a   (a),
        .op_b   (b),
        .done   (iter_done),
        .res_hi (iter_hi),
        .res_lo (iter_lo)
    );

endmodule
